sensor_init_seq: RTL and testbench
==================================

Name: sensor_init_seq

Overview:
- Sequences the camera-sensor register initialisation table held in the 512x16 Gowin_pROM.
- Each table entry is two consecutive words: an even word holding the 16-bit register address, then an odd word whose [7:0] is the register value.
- Walks the table and hands each write to the SCCB master over a valid/ready + completion handshake. Inserts delays, retries NACKed writes, and reports done/error to the top level.

Parameters:
- AW, 9, pROM word-address width; the table holds 2^(AW-1) = 256 entries max.
- POWERUP_CYCLES, 24'd2700000, wait after start before the first ROM read.
- SWRST_CYCLES, 24'd270000, wait after any write to reg 0x3008 with data[7]=1 (sensor soft reset).
- DELAY_UNIT, 16'd27000, cycles per count of a delay entry (≈1 ms at 27 MHz).
- MAX_RETRY, 2, re-issues allowed per entry after NACK.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a run; ignored while busy=1
- rom_ad  out  AW  pROM word address
- rom_ce  out  1  pROM read enable
- rom_oce  out  1  pROM output enable; constant 1
- rom_dout  in  16  pROM read data, valid the cycle after rom_ce=1
- sccb_valid  out  1  write command valid
- sccb_ready  in  1  SCCB master accepts the command
- sccb_reg  out  16  register address
- sccb_data  out  8  register value
- sccb_done  in  1  one-cycle pulse when the bus transfer has finished
- sccb_nack  in  1  qualifies sccb_done; 1 = slave NACK
- busy  out  1  a run is in progress
- done  out  1  sticky; table completed
- error  out  1  sticky; run aborted
- entry_cnt  out  8  number of entries written successfully in this run

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE; rom_ad=0, rom_ce=0, sccb_valid=0, sccb_reg=0, sccb_data=0, busy=0, done=0, error=0, entry_cnt=0, all counters 0; rom_oce=1.
- Reset mid-run: the FSM returns to IDLE at that edge and sccb_valid drops. Any in-flight SCCB transfer is abandoned; its later sccb_done is ignored.
- FSM states: IDLE, PWRUP, RD_A, LAT_A, RD_D, LAT_D, DECODE, ISSUE, WAIT, DELAY, FIN, FAIL.
- IDLE: on start, clear done, error and entry_cnt, set ptr=0, set busy=1, go to PWRUP.
- PWRUP: count POWERUP_CYCLES, then go to RD_A.
- RD_A: rom_ad={ptr,1'b0}, rom_ce=1 for one cycle, go to LAT_A.
- LAT_A: latch rom_dout into reg_q, go to RD_D.
- RD_D: rom_ad={ptr,1'b1}, rom_ce=1 for one cycle, go to LAT_D.
- LAT_D: latch rom_dout[7:0] into dat_q (upper byte ignored), go to DECODE.
- Read timing: one ROM word costs 2 cycles; one entry costs 5 cycles to reach DECODE.
- DECODE:
  - reg_q=0xFFFF: terminator, go to FIN.
  - reg_q=0xFFFE: delay entry; load DELAY_UNIT*dat_q, go to DELAY. If dat_q=0, advance straight to the next entry.
  - Otherwise: drive sccb_reg=reg_q, sccb_data=dat_q, retry=0, go to ISSUE.
- ISSUE:
  - sccb_valid=1; sccb_reg and sccb_data are held stable while valid=1 and ready=0.
  - Transfer occurs on the cycle where valid=1 and ready=1; sccb_valid deasserts the next cycle; go to WAIT.
- WAIT: wait for sccb_done.
  - sccb_nack=0: entry_cnt+1 (saturates at 255).
    - If reg_q=0x3008 and dat_q[7]=1, load SWRST_CYCLES and go to DELAY.
    - Otherwise advance to the next entry.
  - sccb_nack=1, retry<MAX_RETRY: retry+1, return to ISSUE.
  - sccb_nack=1, retry=MAX_RETRY: go to FAIL.
- DELAY: count down to 0, then advance to the next entry.
- Advance: ptr+1, go to RD_A. If ptr was 255 (table exhausted without a terminator), go to FAIL instead; no wrap.
- Delay entries and the terminator never increment entry_cnt and never touch the SCCB handshake.
- FIN: done=1, busy=0, go to IDLE.
- FAIL: error=1, busy=0, go to IDLE.
- done and error stay set until the next start or reset.
- start coincident with reset: reset wins.
- start while busy=1: ignored.

Test Plan:
- Normal run with ROM image {0x3103,0x0011},{0x3008,0x0082},{0x3008,0x0042},{0xFFFF,0xFFFF}, POWERUP_CYCLES=10, SWRST_CYCLES=50, ready=1, done pulse 3 cycles after accept -> 3 SCCB writes in order (3103/11, 3008/82, 3008/42). Gap between write 2's sccb_done and write 3's valid ≥ 50+5 cycles. done=1, entry_cnt=3, busy=0.
- Backpressure: hold sccb_ready=0 for 20 cycles -> sccb_valid stays 1 and sccb_reg/sccb_data stay constant throughout; exactly one accept.
- NACK: NACK the first transfer twice, then ACK it, with MAX_RETRY=2 -> 3 issues of the same command, no error. NACK 3 times -> error=1, done=0, entry_cnt=0.
- Delay entry {0xFFFE,0x0003} with DELAY_UNIT=4 -> no SCCB activity for 12 cycles, then the next entry is read; entry_cnt unaffected.
- No terminator (ROM filled with 0x0000) -> 256 writes, then error=1. Reset asserted mid-ISSUE -> next cycle sccb_valid=0, busy=0, all outputs at reset values.

Source files
------------

// File: rtl/sensor_init_seq.sv
// Walks the camera-sensor init table in pROM and issues each register write
// to the SCCB master, handling delay entries, soft-reset waits and NACK retries.
module sensor_init_seq #(
  parameter int          AW             = 9,
  parameter logic [23:0] POWERUP_CYCLES = 24'd2700000,
  parameter logic [23:0] SWRST_CYCLES   = 24'd270000,
  parameter logic [15:0] DELAY_UNIT     = 16'd27000,
  parameter int          MAX_RETRY      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rom_ad,
  output logic          rom_ce,
  output logic          rom_oce,
  input  logic [15:0]   rom_dout,
  output logic          sccb_valid,
  input  logic          sccb_ready,
  output logic [15:0]   sccb_reg,
  output logic [7:0]    sccb_data,
  input  logic          sccb_done,
  input  logic          sccb_nack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    entry_cnt
);

  localparam int PW = AW - 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, PWRUP, RD_A, LAT_A, RD_D, LAT_D, DECODE, ISSUE, WAIT, DELAY, FIN, FAIL
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [23:0]    cnt_q, cnt_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [15:0]    reg_q, reg_d;
  logic [7:0]     dat_q, dat_d;
  logic [15:0]    sccb_reg_q, sccb_reg_d;
  logic [7:0]     sccb_data_q, sccb_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic [7:0]     entry_cnt_q, entry_cnt_d;
  logic           advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      reg_q       <= '0;
      dat_q       <= '0;
      sccb_reg_q  <= '0;
      sccb_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      entry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      reg_q       <= reg_d;
      dat_q       <= dat_d;
      sccb_reg_q  <= sccb_reg_d;
      sccb_data_q <= sccb_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      entry_cnt_q <= entry_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    reg_d       = reg_q;
    dat_d       = dat_q;
    sccb_reg_d  = sccb_reg_q;
    sccb_data_d = sccb_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    entry_cnt_d = entry_cnt_q;
    advance     = 1'b0;
    rom_ad      = '0;
    rom_ce      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          entry_cnt_d = '0;
          ptr_d       = '0;
          busy_d      = 1'b1;
          cnt_d       = POWERUP_CYCLES;
          state_d     = PWRUP;
        end
      end
      PWRUP: begin
        if (cnt_q == '0) state_d = RD_A;
        else             cnt_d   = cnt_q - 24'd1;
      end
      RD_A: begin
        rom_ad  = {ptr_q, 1'b0};
        rom_ce  = 1'b1;
        state_d = LAT_A;
      end
      LAT_A: begin
        reg_d   = rom_dout;
        state_d = RD_D;
      end
      RD_D: begin
        rom_ad  = {ptr_q, 1'b1};
        rom_ce  = 1'b1;
        state_d = LAT_D;
      end
      LAT_D: begin
        dat_d   = rom_dout[7:0];
        state_d = DECODE;
      end
      DECODE: begin
        if (reg_q == 16'hFFFF) begin
          state_d = FIN;
        end else if (reg_q == 16'hFFFE) begin
          if (dat_q == 8'd0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = 24'(DELAY_UNIT) * 24'(dat_q);
            state_d = DELAY;
          end
        end else begin
          sccb_reg_d  = reg_q;
          sccb_data_d = dat_q;
          retry_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (sccb_ready) state_d = WAIT;
      end
      // A NACK re-issues the held command until the retry budget is spent.
      WAIT: begin
        if (sccb_done) begin
          if (!sccb_nack) begin
            if (entry_cnt_q != 8'hFF) entry_cnt_d = entry_cnt_q + 8'd1;
            if (reg_q == 16'h3008 && dat_q[7]) begin
              cnt_d   = SWRST_CYCLES;
              state_d = DELAY;
            end else begin
              advance = 1'b1;
            end
          end else if (retry_q == RW'(MAX_RETRY)) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - 24'd1;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      FAIL: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Running off the end of the table without a terminator is an error.
    if (advance) begin
      if (ptr_q == '1) begin
        state_d = FAIL;
      end else begin
        ptr_d   = ptr_q + 1'b1;
        state_d = RD_A;
      end
    end
  end

  assign rom_oce    = 1'b1;
  assign sccb_valid = (state_q == ISSUE);
  assign sccb_reg   = sccb_reg_q;
  assign sccb_data  = sccb_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign entry_cnt  = entry_cnt_q;

endmodule

// File: tb/tb_sensor_init_seq.sv
// Directed bench for sensor_init_seq: behavioural pROM plus an SCCB slave
// model with programmable stall and NACK behaviour.
module tb_sensor_init_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic [15:0] rom_dout = '0;
  logic        sccb_valid;
  logic        sccb_ready = 1'b0;
  logic [15:0] sccb_reg;
  logic [7:0]  sccb_data;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  entry_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rom_mem [0:511];

  int          cyc = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          vcyc = 0;
  int          done_timer = 0;
  int          changed_cnt = 0;
  bit          in_cmd = 1'b0;
  bit          pend_nack = 1'b0;
  logic [15:0] last_reg = '0;
  logic [7:0]  last_data = '0;
  logic [15:0] acc_reg   [0:1023];
  logic [7:0]  acc_data  [0:1023];
  int          acc_stall [0:1023];
  int          vstart    [0:1023];
  int          done_cyc  [0:1023];

  int stall_acc = -1;
  int stall_len = 0;
  int nack_until = 0;

  sensor_init_seq #(
    .AW(9),
    .POWERUP_CYCLES(24'd10),
    .SWRST_CYCLES(24'd50),
    .DELAY_UNIT(16'd4),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rom_ad(rom_ad),
    .rom_ce(rom_ce),
    .rom_oce(rom_oce),
    .rom_dout(rom_dout),
    .sccb_valid(sccb_valid),
    .sccb_ready(sccb_ready),
    .sccb_reg(sccb_reg),
    .sccb_data(sccb_data),
    .sccb_done(sccb_done),
    .sccb_nack(sccb_nack),
    .busy(busy),
    .done(done),
    .error(error),
    .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_ce) rom_dout <= rom_mem[rom_ad];
  end

  // Slave decides ready on the falling edge, so an accept lands on the next rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    if (done_timer > 0) begin
      done_timer = done_timer - 1;
      if (done_timer == 0) begin
        sccb_done = 1'b1;
        sccb_nack = pend_nack;
        done_cyc[n_done] = cyc;
        n_done = n_done + 1;
      end
    end
    if (sccb_valid) begin
      if (!in_cmd) begin
        vstart[n_acc] = cyc;
        in_cmd = 1'b1;
        vcyc = 0;
      end else if (sccb_reg != last_reg || sccb_data != last_data) begin
        changed_cnt = changed_cnt + 1;
      end
      last_reg  = sccb_reg;
      last_data = sccb_data;
      if (n_acc == stall_acc && vcyc < stall_len) begin
        sccb_ready = 1'b0;
        vcyc = vcyc + 1;
      end else begin
        sccb_ready = 1'b1;
        acc_reg[n_acc]   = sccb_reg;
        acc_data[n_acc]  = sccb_data;
        acc_stall[n_acc] = vcyc;
        pend_nack = (n_acc < nack_until);
        done_timer = 3;
        n_acc = n_acc + 1;
        in_cmd = 1'b0;
      end
    end else begin
      in_cmd = 1'b0;
      sccb_ready = 1'b0;
    end
  end

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 512; i++) rom_mem[i] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: busy=%0b after %0d cycles, required 0", tag, busy, max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error: got %0b want 0", error); end
    vectors++; if (entry_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_entry_cnt: got %0d want 0", entry_cnt); end
    vectors++; if (sccb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0b want 0", sccb_valid); end
    vectors++; if (rom_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rom_ce: got %0b want 0", rom_ce); end
    vectors++; if (rom_ad !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_rom_ad: got %0h want 0", rom_ad); end
    vectors++; if (rom_oce !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rom_oce: got %0b want 1", rom_oce); end
    vectors++; if (sccb_reg !== 16'h0000 || sccb_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_sccb_bus: got %h/%h want 0000/00", sccb_reg, sccb_data); end
  endtask

  task automatic test_normal_run();
    int base, bd, gap;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h3103; rom_mem[1] = 16'h0011;
    rom_mem[2] = 16'h3008; rom_mem[3] = 16'h0082;
    rom_mem[4] = 16'h3008; rom_mem[5] = 16'h0042;
    base = n_acc;
    bd = n_done;
    pulse_start();
    for (int i = 0; i < 500 && n_acc == base; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(3000, "normal");
    gap = vstart[base+2] - done_cyc[bd+1];
    vectors++; if (n_acc - base !== 3) begin miscompares++; $display("[TB] FAIL normal_writes: got %0d want 3", n_acc - base); end
    vectors++; if (acc_reg[base] !== 16'h3103 || acc_data[base] !== 8'h11) begin miscompares++; $display("[TB] FAIL normal_w1: got %h/%h want 3103/11", acc_reg[base], acc_data[base]); end
    vectors++; if (acc_reg[base+1] !== 16'h3008 || acc_data[base+1] !== 8'h82) begin miscompares++; $display("[TB] FAIL normal_w2: got %h/%h want 3008/82", acc_reg[base+1], acc_data[base+1]); end
    vectors++; if (acc_reg[base+2] !== 16'h3008 || acc_data[base+2] !== 8'h42) begin miscompares++; $display("[TB] FAIL normal_w3: got %h/%h want 3008/42", acc_reg[base+2], acc_data[base+2]); end
    vectors++; if (gap < 55 || gap > 60) begin miscompares++; $display("[TB] FAIL normal_swrst_gap: got %0d want 55..60", gap); end
    vectors++; if (done !== 1'b1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL normal_status: got done=%0b error=%0b want 1/0", done, error); end
    vectors++; if (entry_cnt !== 8'd3) begin miscompares++; $display("[TB] FAIL normal_entry_cnt: got %0d want 3", entry_cnt); end
  endtask

  task automatic test_backpressure();
    int base, cbase;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h1234; rom_mem[1] = 16'hFFAB;
    base = n_acc;
    cbase = changed_cnt;
    stall_acc = n_acc;
    stall_len = 20;
    pulse_start();
    wait_idle(1000, "backpressure");
    stall_acc = -1;
    vectors++; if (n_acc - base !== 1) begin miscompares++; $display("[TB] FAIL bp_accepts: got %0d want 1", n_acc - base); end
    vectors++; if (acc_stall[base] !== 20) begin miscompares++; $display("[TB] FAIL bp_valid_held: got %0d stalled cycles want 20", acc_stall[base]); end
    vectors++; if (changed_cnt - cbase !== 0) begin miscompares++; $display("[TB] FAIL bp_stable: got %0d changes want 0", changed_cnt - cbase); end
    vectors++; if (acc_reg[base] !== 16'h1234 || acc_data[base] !== 8'hAB) begin miscompares++; $display("[TB] FAIL bp_cmd: got %h/%h want 1234/AB", acc_reg[base], acc_data[base]); end
    vectors++; if (done !== 1'b1 || entry_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL bp_status: got done=%0b cnt=%0d want 1/1", done, entry_cnt); end
  endtask

  task automatic test_nack_retry();
    int base;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h3103; rom_mem[1] = 16'h0011;
    base = n_acc;
    nack_until = n_acc + 2;
    pulse_start();
    wait_idle(1000, "nack_retry");
    vectors++; if (n_acc - base !== 3) begin miscompares++; $display("[TB] FAIL retry_issues: got %0d want 3", n_acc - base); end
    vectors++; if (acc_reg[base+2] !== 16'h3103 || acc_data[base+2] !== 8'h11 || acc_reg[base+1] !== 16'h3103) begin miscompares++; $display("[TB] FAIL retry_same_cmd: got %h/%h want 3103/11", acc_reg[base+2], acc_data[base+2]); end
    vectors++; if (error !== 1'b0 || done !== 1'b1) begin miscompares++; $display("[TB] FAIL retry_status: got error=%0b done=%0b want 0/1", error, done); end
    vectors++; if (entry_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL retry_entry_cnt: got %0d want 1", entry_cnt); end
  endtask

  task automatic test_nack_fail();
    int base;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h3103; rom_mem[1] = 16'h0011;
    base = n_acc;
    nack_until = n_acc + 3;
    pulse_start();
    wait_idle(1000, "nack_fail");
    vectors++; if (n_acc - base !== 3) begin miscompares++; $display("[TB] FAIL nackfail_issues: got %0d want 3", n_acc - base); end
    vectors++; if (error !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL nackfail_status: got error=%0b done=%0b want 1/0", error, done); end
    vectors++; if (entry_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL nackfail_entry_cnt: got %0d want 0", entry_cnt); end
  endtask

  task automatic test_delay_entry();
    int base, bd, gap;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h3103; rom_mem[1] = 16'h0011;
    rom_mem[2] = 16'hFFFE; rom_mem[3] = 16'h0003;
    rom_mem[4] = 16'h3104; rom_mem[5] = 16'h0022;
    base = n_acc;
    bd = n_done;
    pulse_start();
    wait_idle(1000, "delay");
    gap = vstart[base+1] - done_cyc[bd];
    vectors++; if (n_acc - base !== 2) begin miscompares++; $display("[TB] FAIL delay_writes: got %0d want 2", n_acc - base); end
    vectors++; if (acc_reg[base+1] !== 16'h3104 || acc_data[base+1] !== 8'h22) begin miscompares++; $display("[TB] FAIL delay_next_cmd: got %h/%h want 3104/22", acc_reg[base+1], acc_data[base+1]); end
    vectors++; if (gap < 22 || gap > 26) begin miscompares++; $display("[TB] FAIL delay_gap: got %0d want 22..26", gap); end
    vectors++; if (entry_cnt !== 8'd2 || done !== 1'b1) begin miscompares++; $display("[TB] FAIL delay_status: got cnt=%0d done=%0b want 2/1", entry_cnt, done); end
  endtask

  task automatic test_no_terminator();
    int base;
    fill_rom(16'h0000);
    base = n_acc;
    pulse_start();
    wait_idle(6000, "noterm");
    vectors++; if (n_acc - base !== 256) begin miscompares++; $display("[TB] FAIL noterm_writes: got %0d want 256", n_acc - base); end
    vectors++; if (error !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL noterm_status: got error=%0b done=%0b want 1/0", error, done); end
    vectors++; if (entry_cnt !== 8'd255) begin miscompares++; $display("[TB] FAIL noterm_entry_cnt_sat: got %0d want 255", entry_cnt); end
  endtask

  task automatic test_reset_mid_issue();
    int base;
    bit seen = 1'b0;
    fill_rom(16'hFFFF);
    rom_mem[0] = 16'h3103; rom_mem[1] = 16'h0011;
    base = n_acc;
    stall_acc = n_acc;
    stall_len = 1000;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (sccb_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (!seen) begin miscompares++; $display("[TB] FAIL midreset_reach_issue: valid=%0b want 1", sccb_valid); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (sccb_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_valid_busy: got %0b/%0b want 0/0", sccb_valid, busy); end
    vectors++; if (sccb_reg !== 16'h0 || sccb_data !== 8'h0 || entry_cnt !== 8'd0 || done !== 1'b0 || error !== 1'b0 || rom_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_outputs: got %h/%h cnt=%0d d=%0b e=%0b ce=%0b want 0", sccb_reg, sccb_data, entry_cnt, done, error, rom_ce); end
    @(negedge clk);
    reset = 1'b0;
    stall_acc = -1;
    repeat (20) @(negedge clk);
    vectors++; if (n_acc - base !== 0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_idle: got accepts=%0d busy=%0b want 0/0", n_acc - base, busy); end
  endtask

  initial begin
    fill_rom(16'hFFFF);
    test_reset();
    test_normal_run();
    test_backpressure();
    test_nack_retry();
    test_nack_fail();
    test_delay_entry();
    test_no_terminator();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
